relu_tile_sched: RTL and testbench
==================================

Name: relu_tile_sched

Overview:
- Sequences a layer's pre-activation data through the shared 4-neuron x 4-input ReLU stage, one 16-value tile at a time.
- Fetches each tile from a synchronous activation buffer and loads the stage's operand inputs.
- Pulses the stage's in_ready, waits for its relu_ready, then captures the 16 results and streams them out with valid/ready.
- Sits between the layer activation buffer and the next-layer MAC input FIFO.

Parameters:
- RELU_SIZE, 5, bit width of one signed activation value.
- ADDR_W, 8, tile address width; maximum tiles per run is 2**ADDR_W - 1.
- TIMEOUT, 64, maximum cycles to wait for relu_ready (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled in IDLE only.
- num_tiles  in  ADDR_W  tile count for the run; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the run completes.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer tile address.
- rd_data  in  16*RELU_SIZE  tile data, valid the cycle after rd_en; value k occupies bits [k*RELU_SIZE +: RELU_SIZE]; k = 4*neuron + input.
- relu_in  out  16*RELU_SIZE  registered operands to the stage, same packing as rd_data.
- relu_in_ready  out  1  one-cycle issue pulse to the stage.
- relu_ready  in  1  stage result-valid level.
- relu_out  in  16*RELU_SIZE  stage results, same packing.
- out_valid  out  1  output tile valid.
- out_ready  in  1  downstream accept.
- out_data  out  16*RELU_SIZE  captured results.
- out_last  out  1  high with out_valid on the final tile of a run.
- err  out  1  timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: all outputs are 0, relu_in is 0, tile counter is 0, state is IDLE. Reset has priority in any state and aborts a run mid-operation with no done pulse.
- IDLE:
  - start=1 and num_tiles>0: latch num_tiles, clear tile count, go to FETCH.
  - start=1 and num_tiles=0: pulse done for one cycle next cycle and stay in IDLE; busy stays 0.
  - start is ignored in every state other than IDLE.
- FETCH: rd_en=1, rd_addr=tile count, for exactly one cycle; go to LOAD.
- LOAD: register rd_data into relu_in; go to ISSUE.
- ISSUE: relu_in_ready=1 for one cycle; relu_in is held stable from LOAD until the tile is captured; go to WAIT.
- WAIT:
  - relu_ready is checked starting the cycle after ISSUE; any relu_ready in the ISSUE cycle itself is ignored.
  - On the first cycle relu_ready=1, register relu_out into out_data; go to OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_valid and out_ready are both high (fire).
  - out_last = (tile count == latched num_tiles - 1).
  - On fire with a tile remaining: increment tile count, go to FETCH.
  - On fire of the last tile: go to DONE.
  - out_ready high before out_valid has no effect.
- DONE: done=1 and busy=0 in this cycle; go to IDLE. A start in the DONE cycle is ignored.
- Minimum per-tile latency, from FETCH to out_valid, is 4 cycles plus the stage latency. Tiles never overlap: one tile is in flight at a time.
- The tile counter never wraps because num_tiles <= 2**ADDR_W - 1.
- No arithmetic is performed on data; values pass through bit-exact.

Optional Feature:
- Macro: RELU_TILE_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT and counts each WAIT cycle.
  - If it reaches TIMEOUT with relu_ready still 0: set err=1 (sticky until rst), abort the run, go to DONE (done pulses), and emit no out_valid for that tile.
- Not defined: no counter is built, err is tied 0, and WAIT waits indefinitely.

Test Plan:
- rst held 3 cycles mid-WAIT -> next cycle all outputs 0, state IDLE, no done pulse; a subsequent start runs normally.
- start with num_tiles=1, rd_data = 16 values (0,-1,2,-3,...), stage model with 2-cycle latency -> exactly one rd_en at addr 0, one relu_in_ready pulse, out_data equal to the model results, out_last=1, done pulses one cycle after fire.
- num_tiles=3, out_ready low for 5 cycles on tile 1 -> out_data stable throughout the stall; addresses 0,1,2 are read in order; out_last is set only on tile 2.
- start with num_tiles=0 -> done pulses one cycle later; busy, rd_en and relu_in_ready never assert.
- start pulsed again while busy, and in the DONE cycle -> ignored; the tile count and sequence are unchanged.
- With RELU_TILE_SCHED_TIMEOUT_EN, TIMEOUT=8, and relu_ready stuck 0 -> err=1 after 8 WAIT cycles, done pulses, no out_valid; err stays high until rst.

Source files
------------

// File: rtl/relu_tile_sched.sv
// -----------------------------------------------------------------------------
// relu_tile_sched
//
// Purpose:
//   Walks a layer's pre-activation data through a shared 4-neuron x 4-input
//   ReLU stage, one 16-value tile at a time. For each tile it reads the
//   activation buffer, registers the operands into the stage, issues a
//   one-cycle request, waits for the stage's result-valid level, captures the
//   16 results and offers them downstream with a valid/ready handshake.
//   Exactly one tile is in flight at any time. Data passes through bit-exact.
//
// Optional feature (macro RELU_TILE_SCHED_TIMEOUT_EN):
//   Bounds the wait for relu_ready to TIMEOUT cycles. On expiry the run is
//   aborted, err is raised (sticky until rst) and done pulses. Without the
//   macro no wait counter exists, err is tied 0 and the wait is unbounded.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle run request, honoured only in IDLE
//   num_tiles      tile count for the run, sampled with start
//   busy           high from the cycle after start is accepted until done
//   done           one-cycle run-complete pulse
//   rd_en/rd_addr  activation buffer read strobe and tile address
//   rd_data        tile data, valid the cycle after rd_en
//   relu_in        registered stage operands (value k at [k*RELU_SIZE +: RELU_SIZE])
//   relu_in_ready  one-cycle issue pulse to the stage
//   relu_ready     stage result-valid level
//   relu_out       stage results, same packing as relu_in
//   out_valid/out_ready/out_data/out_last  result tile stream
//   err            timeout flag
// -----------------------------------------------------------------------------
module relu_tile_sched #(
  parameter int RELU_SIZE = 5,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         num_tiles,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [16*RELU_SIZE-1:0]   rd_data,
  output logic [16*RELU_SIZE-1:0]   relu_in,
  output logic                      relu_in_ready,
  input  logic                      relu_ready,
  input  logic [16*RELU_SIZE-1:0]   relu_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [16*RELU_SIZE-1:0]   out_data,
  output logic                      out_last,
  output logic                      err
);

  localparam int DATA_W = 16 * RELU_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   num_q;
  logic [ADDR_W-1:0]   tile_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic                issue_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   relu_in_q;
  logic [DATA_W-1:0]   out_data_q;

  logic                last_tile;
  logic                fire;

  // num_q is never 0 while a run is active, so the subtraction cannot wrap.
  assign last_tile = (tile_q == (num_q - ADDR_W'(1)));
  assign fire      = out_valid_q & out_ready;

`ifdef RELU_TILE_SCHED_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic                err_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and wins over every state, so a run can be
    // aborted mid-tile; the wide data registers are cleared too because the
    // reset state of relu_in and out_data is observable at the ports.
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      tile_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      issue_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      relu_in_q   <= '0;
      out_data_q  <= '0;
`ifdef RELU_TILE_SCHED_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low here and are raised only on the
      // transition into the state that owns them, so every output is a
      // flop and each pulse lasts exactly one cycle.
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      issue_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_tiles != '0) begin
              num_q   <= num_tiles;
              tile_q  <= '0;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              state_q <= S_FETCH;
            end else begin
              // Empty run: acknowledge immediately, never go busy.
              done_q  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          // rd_data for tile_q arrives during LOAD.
          state_q <= S_LOAD;
        end

        S_LOAD: begin
          relu_in_q <= rd_data;
          issue_q   <= 1'b1;
          state_q   <= S_ISSUE;
        end

        S_ISSUE: begin
          // relu_ready seen here may be stale from the previous tile, so it
          // is not sampled until WAIT.
`ifdef RELU_TILE_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (relu_ready) begin
            out_data_q  <= relu_out;
            out_valid_q <= 1'b1;
            out_last_q  <= last_tile;
            state_q     <= S_OUT;
          end
`ifdef RELU_TILE_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT WAIT cycles have now elapsed without a result.
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
          end
`endif
        end

        S_OUT: begin
          if (fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              tile_q  <= tile_q + ADDR_W'(1);
              rd_en_q <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          // start is deliberately not looked at in this cycle.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = tile_q;
  assign relu_in       = relu_in_q;
  assign relu_in_ready = issue_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;

`ifdef RELU_TILE_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  // TIMEOUT only matters when the wait counter is built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_relu_tile_sched.sv
// -----------------------------------------------------------------------------
// tb_relu_tile_sched
//
// Self-checking bench for relu_tile_sched. Surrounds the scheduler with a
// behavioural activation buffer and a ReLU stage with configurable latency,
// records port activity on the falling edge, and compares every run against
// the expected tile sequence: addresses 0..n-1 in order, operands equal to
// the buffer contents, results equal to ReLU of the buffer contents, out_last
// only on the final tile and done one cycle after the last handshake.
// -----------------------------------------------------------------------------
module tb_relu_tile_sched;

  localparam int RS = 5;
  localparam int AW = 8;
  localparam int TO = 8;
  localparam int DW = 16 * RS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_tiles;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] relu_in;
  logic          relu_in_ready;
  logic          relu_ready = 1'b0;
  logic [DW-1:0] relu_out = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  relu_tile_sched #(
    .RELU_SIZE (RS),
    .ADDR_W    (AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_tiles     (num_tiles),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .relu_in       (relu_in),
    .relu_in_ready (relu_in_ready),
    .relu_ready    (relu_ready),
    .relu_out      (relu_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .err           (err)
  );

  // ---------------------------------------------------------------------------
  // Reference arithmetic: element-wise ReLU on 16 signed RS-bit values.
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] relu_vec(input logic [DW-1:0] v);
    logic [DW-1:0]        r;
    logic signed [RS-1:0] x;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      x = v[k*RS +: RS];
      r[k*RS +: RS] = (x < 0) ? '0 : x;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Environment: activation buffer (1-cycle read) and ReLU stage model.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [16];
  int            lat  = 2;    // issue cycle -> relu_ready visible, >= 2
  bit            hold = 1'b0; // stage never answers while set
  int            s_cnt = 0;
  logic [DW-1:0] s_pend = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      if (rd_addr < AW'(16)) rd_data <= mem[rd_addr[3:0]];
      else                   rd_data <= '0;
    end
  end

  // relu_ready is a level that stays up until the next issue, so a stale
  // high is present during every ISSUE cycle after the first tile.
  always @(posedge clk) begin
    if (rst) begin
      relu_ready <= 1'b0;
      s_cnt      <= 0;
    end else if (relu_in_ready) begin
      relu_ready <= 1'b0;
      s_pend     <= relu_vec(relu_in);
      s_cnt      <= lat - 1;
    end else if (!hold && s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        relu_ready <= 1'b1;
        relu_out   <= s_pend;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Falling-edge recorder of port activity.
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            done_cyc[$];
  int            fire_cyc[$];
  logic [DW-1:0] fire_data[$];
  bit            fire_last[$];
  int            addr_q[$];
  int            iss_cyc[$];
  logic [DW-1:0] iss_data[$];
  int            busy_cnt = 0;
  int            valid_cnt = 0;
  int            err_cnt = 0;
  int            stab_viol = 0;
  int            ri_viol = 0;
  int            busy_done_viol = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] held_in = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cyc.push_back(cyc);
      if (done && busy) busy_done_viol++;
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (err) err_cnt++;
      if (rd_en) addr_q.push_back(int'(rd_addr));
      if (relu_in_ready) begin
        iss_cyc.push_back(cyc);
        iss_data.push_back(relu_in);
        held_in = relu_in;
      end
      if (prev_valid && !prev_ready &&
          (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stab_viol++;
      if (out_valid && out_ready) begin
        fire_cyc.push_back(cyc);
        fire_data.push_back(out_data);
        fire_last.push_back(out_last);
        if (relu_in !== held_in) ri_viol++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_valid = 1'b0;
    end
    cyc++;
  end

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 16; j++)
        mem[k][j*RS +: RS] = RS'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // One complete run with its own checks. stall_tile/stall_len hold out_ready
  // low while that tile is valid; poke re-pulses start while busy and in the
  // DONE cycle with a different num_tiles.
  // ---------------------------------------------------------------------------
  task automatic run_tiles(input int n, input int stall_tile, input int stall_len,
                           input bit rand_ready, input bit poke, input string tag);
    int a0, i0, f0, d0, b0, s0, r0, bd0;
    int start_cyc, stalled, budget, nf, exp_done, nviol;
    bit seen;
    @(posedge clk); #1;
    a0 = addr_q.size();   i0 = iss_cyc.size(); f0 = fire_cyc.size();
    d0 = done_cyc.size(); b0 = busy_cnt;       s0 = stab_viol;
    r0 = ri_viol;         bd0 = busy_done_viol;
    start = 1'b1; num_tiles = AW'(n); start_cyc = cyc;
    stalled = 0; seen = 1'b0;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (budget = 0; budget < 600; budget++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cyc.size() > d0) begin
        seen = 1'b1;
        break;
      end
      nf = fire_cyc.size() - f0;
      if (out_valid && nf == stall_tile && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else if (rand_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (poke && budget == 3) begin
        start = 1'b1; num_tiles = AW'(n + 3);
      end
      if (poke && fire_cyc.size() > f0 && fire_last[fire_last.size()-1] &&
          fire_cyc[fire_cyc.size()-1] == cyc - 1) begin
        start = 1'b1; num_tiles = AW'(n + 2);
      end
    end
    repeat (6) @(posedge clk);
    #1;

    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_done_seen: no done within 600 cycles", tag);
    end
    compared++;
    if (addr_q.size() - a0 != n) begin
      mismatched++;
      $display("FAIL %s_read_count: observed %0d, expected %0d", tag, addr_q.size() - a0, n);
    end
    for (int k = 0; k < n; k++) begin
      if (a0 + k < addr_q.size()) begin
        compared++;
        if (addr_q[a0+k] != k) begin
          mismatched++;
          $display("FAIL %s_rd_addr[%0d]: observed %0d, expected %0d", tag, k, addr_q[a0+k], k);
        end
      end
    end
    compared++;
    if (iss_cyc.size() - i0 != n) begin
      mismatched++;
      $display("FAIL %s_issue_count: observed %0d, expected %0d", tag, iss_cyc.size() - i0, n);
    end
    for (int k = 0; k < n; k++) begin
      if (i0 + k < iss_data.size()) begin
        compared++;
        if (iss_data[i0+k] !== mem[k]) begin
          mismatched++;
          $display("FAIL %s_relu_in[%0d]: observed %0h, expected %0h", tag, k, iss_data[i0+k], mem[k]);
        end
      end
    end
    compared++;
    if (fire_cyc.size() - f0 != n) begin
      mismatched++;
      $display("FAIL %s_tile_count: observed %0d, expected %0d", tag, fire_cyc.size() - f0, n);
    end
    for (int k = 0; k < n; k++) begin
      if (f0 + k < fire_data.size()) begin
        compared++;
        if (fire_data[f0+k] !== relu_vec(mem[k])) begin
          mismatched++;
          $display("FAIL %s_out_data[%0d]: observed %0h, expected %0h", tag, k,
                   fire_data[f0+k], relu_vec(mem[k]));
        end
        compared++;
        if (fire_last[f0+k] !== (k == n - 1)) begin
          mismatched++;
          $display("FAIL %s_out_last[%0d]: observed %0b, expected %0b", tag, k,
                   fire_last[f0+k], (k == n - 1));
        end
      end
    end
    compared++;
    if (done_cyc.size() - d0 != 1) begin
      mismatched++;
      $display("FAIL %s_done_count: observed %0d, expected 1", tag, done_cyc.size() - d0);
    end
    if (n == 0)                     exp_done = start_cyc + 1;
    else if (fire_cyc.size() > f0)  exp_done = fire_cyc[fire_cyc.size()-1] + 1;
    else                            exp_done = -1;
    if (done_cyc.size() > d0) begin
      compared++;
      if (done_cyc[d0] != exp_done) begin
        mismatched++;
        $display("FAIL %s_done_cycle: observed %0d, expected %0d", tag, done_cyc[d0], exp_done);
      end
      compared++;
      if (busy_cnt - b0 != done_cyc[d0] - start_cyc - 1) begin
        mismatched++;
        $display("FAIL %s_busy_cycles: observed %0d, expected %0d", tag, busy_cnt - b0,
                 done_cyc[d0] - start_cyc - 1);
      end
    end
    nviol = (stab_viol - s0) + (ri_viol - r0) + (busy_done_viol - bd0);
    compared++;
    if (nviol != 0) begin
      mismatched++;
      $display("FAIL %s_stability: observed %0d violations (out %0d, relu_in %0d, busy@done %0d), expected 0",
               tag, nviol, stab_viol - s0, ri_viol - r0, busy_done_viol - bd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num_tiles = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if ({busy, done, rd_en, relu_in_ready, out_valid, out_last, err} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: observed %b, expected 0000000",
               {busy, done, rd_en, relu_in_ready, out_valid, out_last, err});
    end
    compared++;
    if (rd_addr !== '0) begin
      mismatched++;
      $display("FAIL reset_rd_addr: observed %0h, expected 0", rd_addr);
    end
    compared++;
    if (relu_in !== '0) begin
      mismatched++;
      $display("FAIL reset_relu_in: observed %0h, expected 0", relu_in);
    end
    compared++;
    if (out_data !== '0) begin
      mismatched++;
      $display("FAIL reset_out_data: observed %0h, expected 0", out_data);
    end
  endtask

  task automatic test_single_tile;
    logic [DW-1:0] pat, exp;
    logic signed [RS-1:0] v;
    pat = '0; exp = '0;
    for (int k = 0; k < 16; k++) begin
      v = (k % 2 == 0) ? RS'(k) : RS'(-k);
      pat[k*RS +: RS] = v;
      exp[k*RS +: RS] = (k % 2 == 0) ? RS'(k) : '0;
    end
    mem[0] = pat;
    lat = 2;
    run_tiles(1, -1, 0, 1'b0, 1'b0, "single");
    compared++;
    if (fire_data.size() == 0 || fire_data[fire_data.size()-1] !== exp) begin
      mismatched++;
      $display("FAIL single_pattern: observed %0h, expected %0h",
               (fire_data.size() == 0) ? '0 : fire_data[fire_data.size()-1], exp);
    end
  endtask

  task automatic test_stall;
    fill_rand(3);
    lat = 3;
    run_tiles(3, 1, 5, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_zero_tiles;
    run_tiles(0, -1, 0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_start_ignored;
    fill_rand(2);
    lat = 2;
    run_tiles(2, -1, 0, 1'b0, 1'b1, "poke");
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 5; r++) begin
      fill_rand(16);
      lat = $urandom_range(2, 5);
      run_tiles($urandom_range(1, 6), -1, 0, 1'b1, 1'b0, $sformatf("b2b%0d", r));
    end
  endtask

  task automatic test_reset_mid_wait;
    int i0, d0, b;
    @(posedge clk); #1;
    hold = 1'b1; fill_rand(2);
    i0 = iss_cyc.size();
    start = 1'b1; num_tiles = AW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (b = 0; b < 50 && iss_cyc.size() == i0; b++) begin
      @(posedge clk); #1;
    end
    compared++;
    if (iss_cyc.size() == i0) begin
      mismatched++;
      $display("FAIL midwait_issue: observed no issue within 50 cycles, expected one");
    end
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cyc.size();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if ({busy, done, rd_en, relu_in_ready, out_valid, out_last, err} !== 7'b0) begin
      mismatched++;
      $display("FAIL midwait_ctrl: observed %b, expected 0000000",
               {busy, done, rd_en, relu_in_ready, out_valid, out_last, err});
    end
    compared++;
    if (rd_addr !== '0 || relu_in !== '0 || out_data !== '0) begin
      mismatched++;
      $display("FAIL midwait_data: observed addr %0h relu_in %0h out_data %0h, expected all 0",
               rd_addr, relu_in, out_data);
    end
    hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (done_cyc.size() != d0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midwait_no_done: observed %0d done pulses busy=%b, expected 0 and 0",
               done_cyc.size() - d0, busy);
    end
    fill_rand(2);
    lat = 2;
    run_tiles(2, -1, 0, 1'b0, 1'b0, "after_rst");
  endtask

`ifdef RELU_TILE_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int i0, d0, v0, a0, b;
    @(posedge clk); #1;
    hold = 1'b1; fill_rand(2); out_ready = 1'b1;
    i0 = iss_cyc.size(); d0 = done_cyc.size(); v0 = valid_cnt; a0 = addr_q.size();
    start = 1'b1; num_tiles = AW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (b = 0; b < 100 && done_cyc.size() == d0; b++) begin
      @(posedge clk); #1;
    end
    compared++;
    if (done_cyc.size() - d0 != 1) begin
      mismatched++;
      $display("FAIL timeout_done: observed %0d done pulses, expected 1", done_cyc.size() - d0);
    end
    if (done_cyc.size() > d0 && iss_cyc.size() > i0) begin
      compared++;
      if (done_cyc[d0] != iss_cyc[i0] + TO + 1) begin
        mismatched++;
        $display("FAIL timeout_cycle: observed %0d, expected %0d", done_cyc[d0], iss_cyc[i0] + TO + 1);
      end
    end
    compared++;
    if (valid_cnt != v0 || addr_q.size() - a0 != 1) begin
      mismatched++;
      $display("FAIL timeout_abort: observed %0d valid cycles %0d reads, expected 0 and 1",
               valid_cnt - v0, addr_q.size() - a0);
    end
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_err_sticky: observed %b, expected 1", err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_err_clear: observed %b, expected 0", err);
    end
    hold = 1'b0;
  endtask
`else
  task automatic test_err_tied;
    compared++;
    if (err_cnt != 0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_tied: observed %0d err cycles, expected 0", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_tile();
    test_stall();
    test_zero_tiles();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef RELU_TILE_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
